// File: rtl/sweep_controller_pkg.sv
// sweep_ctrl_pkg: shared state encoding and sweep enable-count constants.
package sweep_ctrl_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t CLEAR  = 2'd1;
    localparam state_t RUN    = 2'd2;
    localparam state_t FINISH = 2'd3;
    localparam int FIRST_SWEEP_EN = 16;
    localparam int NEXT_SWEEP_EN  = 18;
endpackage

// File: rtl/sweep_controller_if.sv
// sweep_controller_if: command, status and counter-side signals of the sweep controller.
interface sweep_controller_if #(parameter int SWEEP_W = 4);
    logic               START;
    logic [SWEEP_W-1:0] NUM_SWEEPS;
    logic               PAUSE;
    logic               ABORT;
    logic [2:0]         M_IN;
    logic               CNT_EN;
    logic               CNT_SRST;
    logic               BUSY;
    logic               DONE;
    logic [SWEEP_W:0]   SWEEP_CNT;
    modport master (output START, NUM_SWEEPS, PAUSE, ABORT, M_IN,
                    input  CNT_EN, CNT_SRST, BUSY, DONE, SWEEP_CNT);
    modport slave  (input  START, NUM_SWEEPS, PAUSE, ABORT, M_IN,
                    output CNT_EN, CNT_SRST, BUSY, DONE, SWEEP_CNT);
endinterface

// File: rtl/sweep_controller_detect.sv
// sweep_detect: flags a down-count arriving at 0 (previous M of 1, current M of 0).
module sweep_detect (
    input  logic       CLK,
    input  logic       S_RST_N,
    input  logic       en_i,
    input  logic [2:0] m_i,
    output logic       hit_o
);
    logic [2:0] m_prev_q;
    always_ff @(posedge CLK) m_prev_q <= S_RST_N ? m_i : 3'd0;
    assign hit_o = en_i && m_prev_q == 3'd1 && m_i == 3'd0;
endmodule

// File: rtl/sweep_controller.sv
// sweep_controller: clears and runs a bounce counter for a programmed number of sweeps,
// with pause, abort and a one-cycle completion pulse.
module sweep_controller
    import sweep_ctrl_pkg::*;
#(
    parameter int SWEEP_W = 4
) (
    input logic               CLK,
    input logic               S_RST_N,
    sweep_controller_if.slave bus
);
    state_t           state_q, state_d;
    logic [SWEEP_W:0] target_q, target_d, cnt_q, cnt_d;
    logic             run, accept, sweep_hit, last_detect;

    assign run    = state_q == RUN;
    assign accept = state_q == IDLE && bus.START;

    sweep_detect u_detect (
        .CLK     (CLK),
        .S_RST_N (S_RST_N),
        .en_i    (run),
        .m_i     (bus.M_IN),
        .hit_o   (sweep_hit)
    );

    assign last_detect = sweep_hit && (cnt_q + 1'b1 == target_q);

    always_comb begin
        state_d  = state_q == IDLE  ? (bus.START ? CLEAR : IDLE) :
                   state_q == CLEAR ? (bus.ABORT ? FINISH : RUN) :
                   state_q == RUN   ? ((bus.ABORT || last_detect) ? FINISH : RUN) : IDLE;
        // a zero request sets the top bit alone, i.e. 2^SWEEP_W sweeps
        target_d = accept ? {bus.NUM_SWEEPS == '0, bus.NUM_SWEEPS} : target_q;
        cnt_d    = accept ? '0 : (sweep_hit && !bus.ABORT) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (!S_RST_N) begin
            state_q  <= IDLE;
            target_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.CNT_EN    = run && !bus.PAUSE && !bus.ABORT && !last_detect;
    assign bus.CNT_SRST  = !S_RST_N || state_q == CLEAR || state_q == FINISH;
    assign bus.BUSY      = state_q != IDLE;
    assign bus.DONE      = state_q == FINISH;
    assign bus.SWEEP_CNT = cnt_q;
endmodule

// File: tb/tb_sweep_controller.sv
// tb_sweep_controller: directed and randomized runs checked cycle by cycle against a
// timeline predicted from the sweep enable counts, with a behavioural bounce counter.
module tb_sweep_controller;
    import sweep_ctrl_pkg::*;

    logic CLK = 1'b0;
    logic S_RST_N = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    sweep_controller_if #(.SWEEP_W(4)) bus ();
    sweep_controller #(.SWEEP_W(4)) dut (.CLK(CLK), .S_RST_N(S_RST_N), .bus(bus));

    // bounce counter: position within its 18-step period, value from a lookup
    int unsigned phase = 0;
    always_ff @(posedge CLK)
        phase <= bus.CNT_SRST ? 0 : bus.CNT_EN ? (phase == 17 ? 0 : phase + 1) : phase;

    function automatic logic [2:0] bounce(int unsigned p);
        return p <= 7 ? 3'(p) : p <= 9 ? 3'd7 : p <= 15 ? 3'(16 - p) : 3'd0;
    endfunction

    assign bus.M_IN = bounce(phase);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // cycle of the FINISH state and the sweep count reached, relative to START at cycle 0
    task automatic predict(input int k, input int ps, input int pl, input int ab,
                           output int done, output int sw);
        int target, en;
        target = k == 0 ? 16 : k;
        en = 0;
        sw = 0;
        done = 2;
        if (ab == 1) return;
        for (int c = 2; c < 2000; c++) begin
            if (c == ab) begin
                done = c + 1;
                return;
            end
            if (en == FIRST_SWEEP_EN + NEXT_SWEEP_EN * sw) begin
                sw++;
                if (sw == target) begin
                    done = c + 1;
                    return;
                end
            end
            if (!(c >= ps && c < ps + pl)) en++;
        end
    endtask

    task automatic run(input string tag, input int k, input int ps, input int pl, input int ab,
                       input int sp, input int rst_at, input bit hold, output int m7);
        int done, sw, last;
        logic [2:0] mprev;
        bit paused;
        predict(k, ps, pl, ab, done, sw);
        last = rst_at >= 0 ? rst_at + 3 : done + 1;
        m7 = 0;
        mprev = '0;
        for (int c = 0; c <= last; c++) begin
            paused = c >= ps && c < ps + pl;
            bus.START = c == 0 || (c == sp && sp <= done) || (hold && c > 0);
            bus.NUM_SWEEPS = 4'(k);
            bus.PAUSE = paused;
            bus.ABORT = c == ab;
            S_RST_N = c != rst_at;
            #1;
            if (rst_at >= 0 && c > rst_at) begin
                chk({tag, " rst_busy"}, bus.BUSY, 0);
                chk({tag, " rst_done"}, bus.DONE, 0);
                chk({tag, " rst_en"}, bus.CNT_EN, 0);
                chk({tag, " rst_m"}, bus.M_IN, 0);
                chk({tag, " rst_cnt"}, bus.SWEEP_CNT, 0);
            end else if (c == rst_at) begin
                chk({tag, " rst_srst"}, bus.CNT_SRST, 1);
            end else begin
                chk({tag, " busy"}, bus.BUSY, c >= 1 && c <= done);
                chk({tag, " done"}, bus.DONE, c == done);
                chk({tag, " srst"}, bus.CNT_SRST, c == 1 || c == done);
                chk({tag, " en"}, bus.CNT_EN, c >= 2 && c <= done - 2 && !paused);
                if (c == done) chk({tag, " sweep_cnt"}, bus.SWEEP_CNT, sw);
                if (c == done + 1) chk({tag, " m_after"}, bus.M_IN, 0);
            end
            if (c >= 1 && c - 1 >= ps && c - 1 < ps + pl) chk({tag, " pause_hold"}, bus.M_IN, mprev);
            if (bus.M_IN == 3'd7) m7++;
            mprev = bus.M_IN;
            @(negedge CLK);
        end
        S_RST_N = 1'b1;
    endtask

    initial begin
        int m7, k, ps, pl, ab, sp;
        bus.START = 1'b0;
        bus.NUM_SWEEPS = '0;
        bus.PAUSE = 1'b0;
        bus.ABORT = 1'b0;
        S_RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset srst", bus.CNT_SRST, 1);
        chk("reset busy", bus.BUSY, 0);
        chk("reset done", bus.DONE, 0);
        chk("reset en", bus.CNT_EN, 0);
        chk("reset cnt", bus.SWEEP_CNT, 0);
        chk("reset m", bus.M_IN, 0);
        S_RST_N = 1'b1;

        run("single", 1, -1, 0, -1, -1, -1, 1'b0, m7);
        run("multi", 3, -1, 0, -1, -1, -1, 1'b0, m7);
        chk("multi peaks", m7, 9);
        run("pause", 1, 5, 5, -1, -1, -1, 1'b0, m7);
        run("abort", 1, -1, 0, 10, 6, -1, 1'b0, m7);
        run("zero", 0, -1, 0, -1, -1, -1, 1'b0, m7);
        run("midrst", 0, -1, 0, -1, -1, 40, 1'b0, m7);

        run("hold", 1, -1, 0, -1, -1, -1, 1'b1, m7);
        chk("hold restart busy", bus.BUSY, 1);
        chk("hold restart srst", bus.CNT_SRST, 1);
        bus.START = 1'b0;
        S_RST_N = 1'b0;
        @(negedge CLK);
        S_RST_N = 1'b1;
        chk("hold reset idle", bus.BUSY, 0);

        for (int i = 0; i < 8; i++) begin
            k  = $urandom_range(1, 3);
            ps = $urandom_range(2, 40);
            pl = $urandom_range(0, 6);
            ab = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 50)) : -1;
            sp = $urandom_range(1, 30);
            run($sformatf("rand%0d", i), k, ps, pl, ab, sp, -1, 1'b0, m7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
